// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the canonical NOP bubble (addi x0,x0,0) and the default memory-wait timeout.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_TRAP_FLUSH = 2'd2,
    ST_TRAP_WAIT  = 2'd3
  } hazard_state_e;

  localparam logic [31:0] NOP_INSTRUCTION        = 32'h0000_0013;
  localparam int          TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use comparator: flags when the ID instruction reads the
// register that a load currently in EX will write. x0 never creates a hazard.
module load_use_detector (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_memory_read,
  output logic       o_hazard
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_match = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_hazard    = i_ex_memory_read && (i_ex_rd != 5'd0) && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Outputs are Mealy (state + inputs) and forced to 0 while reset is low.
// Optional feature macro: MEM_TIMEOUT_EN -- bounds MEM_WAIT with an 8-bit
// counter and raises bus_error / enters trap when TIMEOUT_CYCLES expires.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       ID_uses_rs1,
  input  logic       ID_uses_rs2,
  input  logic [4:0] EX_rd,
  input  logic       EX_memory_read,
  input  logic       EX_branch_mispredict,
  input  logic       dmem_request,
  input  logic       dmem_ready,
  input  logic       trap_request,
  input  logic       trap_done,
  output logic       pc_stall,
  output logic       IF_ID_stall,
  output logic       ID_EX_stall,
  output logic       EX_MEM_stall,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       EX_MEM_flush,
  output logic       MEM_WB_flush,
  output logic       bus_error,
  output logic [1:0] state
);

  localparam logic [1:0] S_RUN        = ST_RUN;
  localparam logic [1:0] S_MEM_WAIT   = ST_MEM_WAIT;
  localparam logic [1:0] S_TRAP_FLUSH = ST_TRAP_FLUSH;
  localparam logic [1:0] S_TRAP_WAIT  = ST_TRAP_WAIT;

  logic [1:0] r_state;
  logic       r_pending;
  logic [1:0] w_next_state;
  logic       w_pending_next;
  logic       w_load_use;
  logic       w_run_ctl;
  logic       w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall;
  logic       w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wait_cnt;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic       w_bus_error;
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  load_use_detector u_load_use (
    .i_id_rs1        (ID_rs1),
    .i_id_rs2        (ID_rs2),
    .i_id_uses_rs1   (ID_uses_rs1),
    .i_id_uses_rs2   (ID_uses_rs2),
    .i_ex_rd         (EX_rd),
    .i_ex_memory_read(EX_memory_read),
    .o_hazard        (w_load_use)
  );

  // Next-state and Mealy stall/flush decode
  always_comb begin
    w_next_state   = r_state;
    w_pending_next = r_pending;
    w_run_ctl      = 1'b0;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_mem_wb_flush = 1'b0;
`ifdef MEM_TIMEOUT_EN
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_bus_error = 1'b0;
`endif
    case (r_state)
      S_RUN: begin
        if (trap_request) begin
          w_next_state = S_TRAP_FLUSH;
        end else if (dmem_request && !dmem_ready) begin
          w_next_state = S_MEM_WAIT;
          {w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall, w_mem_wb_flush} = 5'b11111;
`ifdef MEM_TIMEOUT_EN
          w_cnt_clr = 1'b1;
`endif
        end else begin
          w_run_ctl = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready) begin
          // A trap seen during the wait is taken only once the access lands
          if (r_pending || trap_request) begin
            w_next_state = S_TRAP_FLUSH;
          end else begin
            w_next_state = S_RUN;
            w_run_ctl    = 1'b1;
          end
        end else begin
          {w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall, w_mem_wb_flush} = 5'b11111;
          if (trap_request) w_pending_next = 1'b1;
`ifdef MEM_TIMEOUT_EN
          if (r_wait_cnt == TIMEOUT_LAST) begin
            w_bus_error  = 1'b1;
            w_next_state = S_TRAP_FLUSH;
          end else begin
            w_cnt_inc = 1'b1;
          end
`endif
        end
      end
      S_TRAP_FLUSH: begin
        w_next_state = S_TRAP_WAIT;
        {w_pc_stall, w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush} = 5'b11111;
      end
      default: begin
        {w_pc_stall, w_if_id_flush, w_id_ex_flush} = 3'b111;
        if (trap_done) w_next_state = S_RUN;
      end
    endcase

    // Mispredict outranks load-use: the stalled ID instruction is discarded anyway
    if (w_run_ctl) begin
      if (EX_branch_mispredict) begin
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        w_pc_stall    = 1'b1;
        w_if_id_stall = 1'b1;
        w_id_ex_flush = 1'b1;
      end
    end

    if (w_next_state == S_TRAP_FLUSH) w_pending_next = 1'b0;
  end

  // FSM state and deferred-trap flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_RUN;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_pending_next;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Memory-wait cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= 8'd0;
    end else if (w_cnt_clr) begin
      r_wait_cnt <= 8'd0;
    end else if (w_cnt_inc) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign bus_error = reset & w_bus_error;
`else
  assign bus_error = 1'b0;
`endif

  assign pc_stall     = reset & w_pc_stall;
  assign IF_ID_stall  = reset & w_if_id_stall;
  assign ID_EX_stall  = reset & w_id_ex_stall;
  assign EX_MEM_stall = reset & w_ex_mem_stall;
  assign IF_ID_flush  = reset & w_if_id_flush;
  assign ID_EX_flush  = reset & w_id_ex_flush;
  assign EX_MEM_flush = reset & w_ex_mem_flush;
  assign MEM_WB_flush = reset & w_mem_wb_flush;
  assign state        = r_state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller. Each cycle the
// expected {state, outputs} word is queued when stimulus is driven and popped
// and compared when the Mealy outputs are sampled, before the next rising edge.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic       ID_uses_rs1, ID_uses_rs2, EX_memory_read, EX_branch_mispredict;
  logic       dmem_request, dmem_ready, trap_request, trap_done;
  logic       pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
  logic       IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, bus_error;
  logic [1:0] state;

  // Output bit positions: {pc,IFs,IDs,EMs,IFf,IDf,EMf,MWf,berr}
  localparam logic [8:0] O_NONE = 9'h000;
  localparam logic [8:0] O_BE   = 9'h001;
  localparam logic [8:0] O_LU   = 9'h100 | 9'h080 | 9'h008;
  localparam logic [8:0] O_MP   = 9'h010 | 9'h008;
  localparam logic [8:0] O_MEM  = 9'h100 | 9'h080 | 9'h040 | 9'h020 | 9'h002;
  localparam logic [8:0] O_TF   = 9'h100 | 9'h010 | 9'h008 | 9'h004 | 9'h002;
  localparam logic [8:0] O_TW   = 9'h100 | 9'h010 | 9'h008;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] exp_q[$];

  pipeline_hazard_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_rd(EX_rd), .EX_memory_read(EX_memory_read), .EX_branch_mispredict(EX_branch_mispredict),
    .dmem_request(dmem_request), .dmem_ready(dmem_ready),
    .trap_request(trap_request), .trap_done(trap_done),
    .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
    .EX_MEM_stall(EX_MEM_stall), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
    .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
               tag, got[10:9], got[8:0], exp[10:9], exp[8:0]);
    end
  endtask

  function automatic logic [10:0] observe();
    return {state, pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
            IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, bus_error};
  endfunction

  task automatic clr_in();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
    EX_rd = 5'd0; EX_memory_read = 1'b0; EX_branch_mispredict = 1'b0;
    dmem_request = 1'b0; dmem_ready = 1'b0; trap_request = 1'b0; trap_done = 1'b0;
  endtask

  // load x5 in EX, add x6,x5,x1 in ID
  task automatic set_load_use();
    EX_memory_read = 1'b1; EX_rd = 5'd5;
    ID_rs1 = 5'd5; ID_uses_rs1 = 1'b1; ID_rs2 = 5'd1; ID_uses_rs2 = 1'b1;
  endtask

  // Inputs already driven at the falling edge; queue expectation, sample, advance
  task automatic cyc(input string tag, input logic [8:0] eo, input logic [1:0] es);
    exp_q.push_back({es, eo});
    #1;
    check_eq(tag, observe(), exp_q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    reset = 1'b0;
    @(negedge clk);

    // Reset: hazards present on inputs must not reach the outputs
    set_load_use(); trap_request = 1'b1; dmem_request = 1'b1; EX_branch_mispredict = 1'b1;
    cyc("rst_hold0", O_NONE, 2'd0);
    cyc("rst_hold1", O_NONE, 2'd0);
    clr_in(); reset = 1'b1;
    cyc("idle", O_NONE, 2'd0);

    // Load-use: exactly one bubble, then the bubble sits in EX
    set_load_use();
    cyc("lu_rs1", O_LU, 2'd0);
    EX_memory_read = 1'b0;
    cyc("lu_after", O_NONE, 2'd0);
    set_load_use(); ID_rs1 = 5'd1; ID_rs2 = 5'd5;
    cyc("lu_rs2", O_LU, 2'd0);
    set_load_use(); ID_uses_rs1 = 1'b0; ID_rs2 = 5'd7;
    cyc("lu_unused_src", O_NONE, 2'd0);
    set_load_use(); EX_rd = 5'd0; ID_rs1 = 5'd0;
    cyc("lu_rd_x0", O_NONE, 2'd0);

    // Mispredict overrides load-use
    set_load_use(); EX_branch_mispredict = 1'b1;
    cyc("mp_over_lu", O_MP, 2'd0);
    clr_in(); EX_branch_mispredict = 1'b1;
    cyc("mp_only", O_MP, 2'd0);

    // Memory wait: ready on the 4th request cycle -> 3 stall cycles
    clr_in(); dmem_request = 1'b1;
    cyc("mw_c1", O_MEM, 2'd0);
    set_load_use(); EX_branch_mispredict = 1'b1;
    cyc("mw_c2_masked", O_MEM, 2'd1);
    clr_in(); dmem_request = 1'b1;
    cyc("mw_c3", O_MEM, 2'd1);
    dmem_ready = 1'b1;
    cyc("mw_ready", O_NONE, 2'd1);
    clr_in();
    cyc("mw_back_run", O_NONE, 2'd0);

    // Trap raised during a memory wait is deferred until the access completes
    dmem_request = 1'b1;
    cyc("mt_c1", O_MEM, 2'd0);
    trap_request = 1'b1;
    cyc("mt_c2", O_MEM, 2'd1);
    cyc("mt_c3", O_MEM, 2'd1);
    cyc("mt_c4", O_MEM, 2'd1);
    dmem_ready = 1'b1;
    cyc("mt_c5_ready", O_NONE, 2'd1);
    dmem_request = 1'b0; dmem_ready = 1'b0;
    cyc("mt_c6_tflush", O_TF, 2'd2);
    cyc("mt_twait", O_TW, 2'd3);
    trap_request = 1'b0;
    cyc("mt_twait2", O_TW, 2'd3);
    trap_done = 1'b1;
    cyc("mt_done", O_TW, 2'd3);
    clr_in();
    cyc("mt_run", O_NONE, 2'd0);

    // Trap from RUN; done and request together returns to RUN, then re-enters
    trap_request = 1'b1;
    cyc("tr_req", O_NONE, 2'd0);
    cyc("tr_flush", O_TF, 2'd2);
    trap_done = 1'b1;
    cyc("tr_done_req", O_TW, 2'd3);
    trap_done = 1'b0;
    cyc("tr_rerun", O_NONE, 2'd0);
    trap_request = 1'b0;
    cyc("tr_flush2", O_TF, 2'd2);
    trap_done = 1'b1;
    cyc("tr_wait2", O_TW, 2'd3);
    clr_in();
    cyc("tr_run2", O_NONE, 2'd0);

`ifdef MEM_TIMEOUT_EN
    // Ready never arrives: bus_error in the 8th wait cycle, then trap entry
    dmem_request = 1'b1;
    cyc("to_entry", O_MEM, 2'd0);
    for (int i = 1; i < 8; i++) cyc($sformatf("to_wait%0d", i), O_MEM, 2'd1);
    cyc("to_error", O_MEM | O_BE, 2'd1);
    dmem_request = 1'b0;
    cyc("to_tflush", O_TF, 2'd2);
    trap_done = 1'b1;
    cyc("to_twait", O_TW, 2'd3);
    clr_in();
    cyc("to_run", O_NONE, 2'd0);
`else
    // Without the timeout the wait is unbounded and bus_error stays low
    dmem_request = 1'b1;
    cyc("long_entry", O_MEM, 2'd0);
    for (int i = 1; i < 12; i++) cyc($sformatf("long_wait%0d", i), O_MEM, 2'd1);
    dmem_ready = 1'b1;
    cyc("long_ready", O_NONE, 2'd1);
    clr_in();
    cyc("long_run", O_NONE, 2'd0);
`endif

    // Asynchronous reset in the middle of a memory wait
    dmem_request = 1'b1;
    cyc("ar_entry", O_MEM, 2'd0);
    cyc("ar_wait", O_MEM, 2'd1);
    #2 reset = 1'b0;
    exp_q.push_back({2'd0, O_NONE});
    #1;
    check_eq("ar_async", observe(), exp_q.pop_front());
    @(negedge clk);
    cyc("ar_held", O_NONE, 2'd0);
    reset = 1'b1; dmem_request = 1'b0;
    cyc("ar_release", O_NONE, 2'd0);
    set_load_use();
    cyc("ar_lu_after", O_LU, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
